mux4_rr_arbiter: RTL and testbench
==================================

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 4, range 1..15: maximum consecutive cycles one requester keeps the grant while others are waiting.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  4  request lines; bit k = requester k wants the shared 4:1 mux.
REQ-005 i0, i1, i2, i3  input  1 each  data from requester 0..3.
REQ-006 gnt  output  4  one-hot grant, or all-zero when idle; registered.
REQ-007 s0  output  1  mux select LSB; registered.
REQ-008 s1  output  1  mux select MSB; registered.
REQ-009 y  output  1  shared-mux output; combinational from the registered select.
REQ-010 valid  output  1  high when y carries granted data; registered.

Function
REQ-011 {s1,s0} SHALL equal the index of the granted requester (00 = i0, 01 = i1, 10 = i2, 11 = i3).
REQ-012 While valid=1, y SHALL equal the input selected by {s1,s0}; while valid=0, y SHALL be 0.
REQ-013 The FSM SHALL have two states: IDLE (gnt=0, valid=0) and GRANT (exactly one gnt bit high, valid=1).
REQ-014 Priority pointer ptr (2 bits) sets the search start; the search order is ptr, ptr+1, ptr+2, ptr+3 mod 4; the first set req bit in that order wins.
REQ-015 IDLE -> GRANT: on an edge where req != 0, grant the winner; gnt, {s1,s0} and valid update at that edge (1-cycle latency from req to gnt).
REQ-016 IDLE -> IDLE when req == 0; outputs stay as they are.
REQ-017 In GRANT to k with req[k]=0 at the edge: if other req bits are set, hand off directly to the winner searched from k+1 (no idle bubble); otherwise go to IDLE.
REQ-018 Hold counter hcnt (4 bits) SHALL clear on every new grant and increment each GRANT cycle in which the same k keeps the grant.
REQ-019 In GRANT to k with req[k]=1: if hcnt == MAX_HOLD-1 and some other req bit is set, hand off to the winner searched from k+1; otherwise keep k.
REQ-020 When k keeps the grant with no competitor, hcnt SHALL saturate at MAX_HOLD-1 and not wrap, so a new competitor forces a handoff at the next edge.
REQ-021 On every grant to k, including re-grants, ptr SHALL become (k+1) mod 4, wrapping 3 -> 0.
REQ-022 req is assumed synchronous to clk; no metastability handling is required.
REQ-023 Grant changes SHALL occur only at clock edges; gnt SHALL never have more than one bit high.

Reset
REQ-024 While rst_n=0, asynchronously and independent of clk: gnt=0000, s0=0, s1=0, valid=0, y=0, ptr=0, hcnt=0, state=IDLE.
REQ-025 Deasserting reset in the middle of a grant SHALL discard it; the first edge after rst_n rises arbitrates from ptr=0.

Verification
REQ-026 Reset with req=1111 held -> outputs stay at reset values while rst_n=0; first edge after release gives gnt=0001, {s1,s0}=00, valid=1.
REQ-027 req=0100 only, i2 toggling -> gnt=0100 one edge later, {s1,s0}=10, y follows i2 each cycle, grant held indefinitely.
REQ-028 MAX_HOLD=4, req=1111 held -> grant sequence 0001 x4, 0010 x4, 0100 x4, 1000 x4, then 0001 again (pointer wraps).
REQ-029 Grant to 0 active, req changes 0001 -> 1000 at one edge -> gnt=1000 at that edge, valid stays 1 with no bubble; then req=0000 -> IDLE, valid=0, y=0.
REQ-030 rst_n pulsed low mid-grant to requester 2 -> asynchronous return to reset values; after release with req=0110, gnt=0010 (ptr=0 search).
REQ-031 Run all 16 req patterns from IDLE with distinct i0..i3 values -> gnt is one-hot or zero, y matches the selected input, and the winner follows the REQ-014 search order.

Source files
------------

// File: rtl/mux4_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mux4_rr_arbiter_if
// Brief    : Request/data/grant bundle between four requesters and the arbiter
// Revision : 1.0
// ============================================================================
interface mux4_rr_arbiter_if;
  logic [3:0] req;
  logic       i0;
  logic       i1;
  logic       i2;
  logic       i3;
  logic [3:0] gnt;
  logic       s0;
  logic       s1;
  logic       y;
  logic       valid;

  modport master (
    output req, i0, i1, i2, i3,
    input  gnt, s0, s1, y, valid
  );

  modport slave (
    input  req, i0, i1, i2, i3,
    output gnt, s0, s1, y, valid
  );
endinterface
`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux4_rr_arbiter
// Brief    : Round-robin 4-way arbiter with hold limit driving a shared 4:1 mux
// Revision : 1.0
// ============================================================================
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  mux4_rr_arbiter_if.slave  bus
);

  localparam logic [3:0] C_HOLD_LAST = 4'(MAX_HOLD - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     r_state;
  logic [3:0] r_gnt;
  logic       r_s0;
  logic       r_s1;
  logic       r_valid;
  logic [1:0] r_ptr;
  logic [3:0] r_hcnt;

  logic [1:0] w_cur;
  logic [3:0] w_others;
  logic [1:0] w_pick_ptr;
  logic [1:0] w_pick_next;
  logic [1:0] w_win;
  logic       w_grant;
  logic       w_go_idle;
  logic       w_keep;
  logic       w_mux;

  // First set bit of r in the circular order start, start+1, start+2, start+3.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    win   = start;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = start + 2'(i);
      if (!found && r[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  assign w_cur       = {r_s1, r_s0};
  assign w_others    = bus.req & ~(4'b0001 << w_cur);
  assign w_pick_ptr  = rr_pick(bus.req, r_ptr);
  assign w_pick_next = rr_pick(w_others, w_cur + 2'd1);

  always_comb begin
    w_grant   = 1'b0;
    w_go_idle = 1'b0;
    w_keep    = 1'b0;
    w_win     = w_pick_ptr;
    if (r_state == IDLE) begin
      w_grant = |bus.req;
    end else if (!bus.req[w_cur] || (r_hcnt == C_HOLD_LAST)) begin
      // Owner dropped or used up its hold budget: hand off without a bubble.
      if (|w_others) begin
        w_grant = 1'b1;
        w_win   = w_pick_next;
      end else if (!bus.req[w_cur]) begin
        w_go_idle = 1'b1;
      end else begin
        w_keep = 1'b1;
      end
    end else begin
      w_keep = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= 4'b0000;
      r_s0    <= 1'b0;
      r_s1    <= 1'b0;
      r_valid <= 1'b0;
      r_ptr   <= 2'd0;
      r_hcnt  <= 4'd0;
    end else if (w_grant) begin
      r_state <= GRANT;
      r_gnt   <= 4'b0001 << w_win;
      r_s0    <= w_win[0];
      r_s1    <= w_win[1];
      r_valid <= 1'b1;
      r_ptr   <= w_win + 2'd1;
      r_hcnt  <= 4'd0;
    end else if (w_go_idle) begin
      r_state <= IDLE;
      r_gnt   <= 4'b0000;
      r_valid <= 1'b0;
      r_hcnt  <= 4'd0;
    end else if (w_keep) begin
      // Saturate so a late competitor is served at the very next edge.
      if (r_hcnt != C_HOLD_LAST) begin
        r_hcnt <= r_hcnt + 4'd1;
      end
    end
  end

  always_comb begin
    case (w_cur)
      2'd0:    w_mux = bus.i0;
      2'd1:    w_mux = bus.i1;
      2'd2:    w_mux = bus.i2;
      default: w_mux = bus.i3;
    endcase
  end

  assign bus.gnt   = r_gnt;
  assign bus.s0    = r_s0;
  assign bus.s1    = r_s1;
  assign bus.valid = r_valid;
  assign bus.y     = r_valid & w_mux;

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux4_rr_arbiter
// Brief    : Directed vector table plus multi-cycle sequences for mux4_rr_arbiter
// Revision : 1.0
// ============================================================================
module tb_mux4_rr_arbiter;

  typedef struct {
    logic [3:0] req;
    logic [3:0] din;   // {i3,i2,i1,i0}
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       y;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;
  vec_t vecs[16];

  mux4_rr_arbiter_if bus();

  mux4_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_out(input string name, input logic [3:0] gnt, input logic [1:0] sel,
                           input logic valid, input logic y);
    check({name, ".gnt"},   8'(bus.gnt), 8'(gnt));
    check({name, ".sel"},   8'({bus.s1, bus.s0}), 8'(sel));
    check({name, ".valid"}, 8'(bus.valid), 8'(valid));
    check({name, ".y"},     8'(bus.y), 8'(y));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [3:0] req, input logic [3:0] din);
    bus.req = req;
    {bus.i3, bus.i2, bus.i1, bus.i0} = din;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    set_in(4'b0000, 4'b0000);

    // Winner from ptr=0 is the lowest set req bit; y = din[winner].
    vecs[0]  = '{4'b0000, 4'b1111, 4'b0000, 2'b00, 1'b0, 1'b0};
    vecs[1]  = '{4'b0001, 4'b0001, 4'b0001, 2'b00, 1'b1, 1'b1};
    vecs[2]  = '{4'b0010, 4'b1101, 4'b0010, 2'b01, 1'b1, 1'b0};
    vecs[3]  = '{4'b0011, 4'b1110, 4'b0001, 2'b00, 1'b1, 1'b0};
    vecs[4]  = '{4'b0100, 4'b0100, 4'b0100, 2'b10, 1'b1, 1'b1};
    vecs[5]  = '{4'b0101, 4'b1011, 4'b0001, 2'b00, 1'b1, 1'b1};
    vecs[6]  = '{4'b0110, 4'b0100, 4'b0010, 2'b01, 1'b1, 1'b0};
    vecs[7]  = '{4'b0111, 4'b0010, 4'b0001, 2'b00, 1'b1, 1'b0};
    vecs[8]  = '{4'b1000, 4'b1000, 4'b1000, 2'b11, 1'b1, 1'b1};
    vecs[9]  = '{4'b1001, 4'b0111, 4'b0001, 2'b00, 1'b1, 1'b1};
    vecs[10] = '{4'b1010, 4'b0010, 4'b0010, 2'b01, 1'b1, 1'b1};
    vecs[11] = '{4'b1011, 4'b1110, 4'b0001, 2'b00, 1'b1, 1'b0};
    vecs[12] = '{4'b1100, 4'b1011, 4'b0100, 2'b10, 1'b1, 1'b0};
    vecs[13] = '{4'b1101, 4'b0001, 4'b0001, 2'b00, 1'b1, 1'b1};
    vecs[14] = '{4'b1110, 4'b1000, 4'b0010, 2'b01, 1'b1, 1'b0};
    vecs[15] = '{4'b1111, 4'b0111, 4'b0001, 2'b00, 1'b1, 1'b1};

    // Reset held with all requests pending, then full round-robin rotation.
    set_in(4'b1111, 4'b1111);
    step(); step(); step();
    check_out("reset_hold", 4'b0000, 2'b00, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    check_out("first_grant", 4'b0001, 2'b00, 1'b1, 1'b1);
    for (int n = 1; n <= 16; n++) begin
      logic [3:0] e;
      logic [1:0] es;
      es = 2'((n / 4) % 4);
      e  = 4'b0001 << es;
      step();
      check($sformatf("rotate[%0d].gnt", n), 8'(bus.gnt), 8'(e));
      check($sformatf("rotate[%0d].sel", n), 8'({bus.s1, bus.s0}), 8'(es));
    end

    // Vector table: each pattern applied from a fresh IDLE with ptr=0.
    for (int v = 0; v < 16; v++) begin
      set_in(4'b0000, 4'b0000);
      pulse_reset();
      set_in(vecs[v].req, vecs[v].din);
      step();
      check_out($sformatf("vec[%0d]", v), vecs[v].gnt, vecs[v].sel, vecs[v].valid, vecs[v].y);
    end

    // Single requester 2 holds indefinitely while i2 toggles; late competitor forces handoff.
    set_in(4'b0000, 4'b0000);
    pulse_reset();
    set_in(4'b0100, 4'b0000);
    step();
    check_out("hold2", 4'b0100, 2'b10, 1'b1, 1'b0);
    for (int c = 0; c < 8; c++) begin
      bus.i2 = ~bus.i2;
      #1;
      check($sformatf("hold2_y[%0d]", c), 8'(bus.y), 8'(bus.i2));
      step();
      check($sformatf("hold2_gnt[%0d]", c), 8'(bus.gnt), 8'(4'b0100));
    end
    set_in(4'b0101, 4'b0001);
    step();
    check_out("hold2_preempt", 4'b0001, 2'b00, 1'b1, 1'b1);

    // Owner drops and another takes over at the same edge, then idle.
    set_in(4'b0000, 4'b0000);
    pulse_reset();
    set_in(4'b0001, 4'b1000);
    step();
    check_out("handoff_a", 4'b0001, 2'b00, 1'b1, 1'b0);
    set_in(4'b1000, 4'b1000);
    step();
    check_out("handoff_b", 4'b1000, 2'b11, 1'b1, 1'b1);
    set_in(4'b0000, 4'b1111);
    step();
    check_out("to_idle", 4'b0000, 2'b11, 1'b0, 1'b0);
    step();
    check_out("idle_stay", 4'b0000, 2'b11, 1'b0, 1'b0);

    // Pointer advanced past requester 0 so requester 1 wins from IDLE.
    set_in(4'b0000, 4'b0000);
    pulse_reset();
    set_in(4'b0001, 4'b0010);
    step();
    set_in(4'b0000, 4'b0010);
    step();
    check_out("ptr_idle", 4'b0000, 2'b00, 1'b0, 1'b0);
    set_in(4'b0011, 4'b0010);
    step();
    check_out("ptr_search", 4'b0010, 2'b01, 1'b1, 1'b1);

    // Asynchronous reset mid-grant, then arbitration restarts from ptr=0.
    set_in(4'b0000, 4'b0000);
    pulse_reset();
    set_in(4'b0100, 4'b0100);
    step();
    check_out("pre_async", 4'b0100, 2'b10, 1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 4'b0000, 2'b00, 1'b0, 1'b0);
    rst_n = 1'b1;
    set_in(4'b0110, 4'b0010);
    step();
    check_out("post_async", 4'b0010, 2'b01, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
